reg_scoreboard: RTL and testbench

- Tracks which architectural registers have a write outstanding from a multi-cycle or pipelined producer. The register file is the storage end; this block sits on the reader and issue side.
- Stalls an instruction at issue while a source (RAW) or destination (WAW) register is pending.
- Clears a register's pending bit when the producer writes back to the register file.
- x0 is never pending.

---
 rtl/scb_pkg.sv | 11 +
 rtl/scb_hazard_chk.sv | 34 +++
 rtl/reg_scoreboard.sv | 85 ++++++++
 tb/tb_reg_scoreboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/scb_pkg.sv
// Shared defaults and types for the register scoreboard (reg_scoreboard).
package scb_pkg;
   localparam int AW      = 5;
   localparam int NREG    = 2 ** AW;
   localparam int MAX_OUT = 4;
   localparam int CW      = 3;

   typedef logic [AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/scb_hazard_chk.sv
// Combinational RAW/WAW hazard detection against the pending bitmap.
// With SCB_WB_BYPASS_EN defined, a same-cycle write-back masks its register.
module scb_hazard_chk
   import scb_pkg::*;
#(
   parameter int NREG = scb_pkg::NREG,
   parameter int AW   = scb_pkg::AW
) (
   input  logic [NREG-1:0] busy,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   input  logic [AW-1:0]   rd,
   input  logic            we,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   output logic            hazard
);

   logic [NREG-1:0] clr;
   logic [NREG-1:0] eff;

`ifdef SCB_WB_BYPASS_EN
   assign clr = wb_valid ? (NREG'(1) << wb_rd) : '0;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_valid, wb_rd};
   assign clr       = '0;
`endif

   // Register 0 is hard-wired clean regardless of what the bitmap holds.
   assign eff    = busy & ~clr & ~NREG'(1);
   assign hazard = eff[rs1] | eff[rs2] | (we & eff[rd]);

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: stalls issue on RAW/WAW hazards or when the outstanding limit is reached.
// Optional macro SCB_WB_BYPASS_EN lets a same-cycle write-back release a stall without a bubble.
module reg_scoreboard
   import scb_pkg::*;
#(
   parameter int NREG    = scb_pkg::NREG,
   parameter int AW      = scb_pkg::AW,
   parameter int MAX_OUT = scb_pkg::MAX_OUT,
   parameter int CW      = scb_pkg::CW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   output logic            iss_ready,
   input  logic [AW-1:0]   iss_rs1,
   input  logic [AW-1:0]   iss_rs2,
   input  logic [AW-1:0]   iss_rd,
   input  logic            iss_we,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   output logic [NREG-1:0] busy,
   output logic [CW-1:0]   out_cnt,
   output logic            err_wb
);

   logic            hazard;
   logic            full;
   logic            fire;
   logic            set_req;
   logic            wb_hit;
   logic            wb_legal;
   logic            wb_bad;
   logic [CW-1:0]   cnt_eff;
   logic [NREG-1:0] busy_next;

   scb_hazard_chk #(
      .NREG (NREG),
      .AW   (AW)
   ) u_hazard (
      .busy     (busy),
      .rs1      (iss_rs1),
      .rs2      (iss_rs2),
      .rd       (iss_rd),
      .we       (iss_we),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .hazard   (hazard)
   );

   assign wb_hit   = wb_valid && (wb_rd != AW'(REG_ZERO));
   assign wb_legal = wb_hit && busy[wb_rd];
   assign wb_bad   = wb_hit && !busy[wb_rd];

`ifdef SCB_WB_BYPASS_EN
   assign cnt_eff = out_cnt - CW'(wb_legal);
`else
   assign cnt_eff = out_cnt;
`endif

   assign full      = iss_we && (iss_rd != AW'(REG_ZERO)) && (cnt_eff == CW'(MAX_OUT));
   assign iss_ready = !hazard && !full;
   assign fire      = iss_valid && iss_ready;
   assign set_req   = fire && iss_we && (iss_rd != AW'(REG_ZERO));

   // Set is applied after clear so a bypassed re-issue of the same register stays pending.
   always_comb begin
      busy_next = busy;
      if (wb_legal) busy_next[wb_rd] = 1'b0;
      if (set_req)  busy_next[iss_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= '0;
         out_cnt <= '0;
         err_wb  <= 1'b0;
      end else begin
         busy    <= busy_next;
         out_cnt <= out_cnt + CW'(set_req) - CW'(wb_legal);
         if (wb_bad) err_wb <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against an array-based reference model.
module tb_reg_scoreboard;
   import scb_pkg::*;

`ifdef SCB_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            iss_valid;
   logic            iss_ready;
   reg_addr_t       iss_rs1, iss_rs2, iss_rd, wb_rd;
   logic            iss_we;
   logic            wb_valid;
   logic [NREG-1:0] busy;
   logic [CW-1:0]   out_cnt;
   logic            err_wb;

   bit pend [NREG];
   int cnt;
   bit err;
   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_we    (iss_we),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .busy      (busy),
      .out_cnt   (out_cnt),
      .err_wb    (err_wb)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic bit still_pending(input int r);
      if (r == 0 || !pend[r]) return 1'b0;
      if (BYP && wb_valid && int'(wb_rd) == r) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_ready();
      bit legal;
      bit haz;
      int c;
      legal = wb_valid && wb_rd != 0 && pend[wb_rd];
      haz = still_pending(int'(iss_rs1)) || still_pending(int'(iss_rs2)) ||
            (iss_we && still_pending(int'(iss_rd)));
      c = cnt - ((BYP && legal) ? 1 : 0);
      return !haz && !(iss_we && iss_rd != 0 && c == MAX_OUT);
   endfunction

   function automatic logic [NREG-1:0] model_busy();
      logic [NREG-1:0] v;
      v = '0;
      for (int i = 0; i < NREG; i++) v[i] = pend[i];
      return v;
   endfunction

   task automatic model_clock(input bit rdy);
      bit legal;
      if (rst) begin
         for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
         cnt = 0;
         err = 1'b0;
         return;
      end
      legal = wb_valid && wb_rd != 0 && pend[wb_rd];
      if (wb_valid && wb_rd != 0 && !pend[wb_rd]) err = 1'b1;
      if (legal) begin
         pend[wb_rd] = 1'b0;
         cnt--;
      end
      if (iss_valid && rdy && iss_we && iss_rd != 0) begin
         pend[iss_rd] = 1'b1;
         cnt++;
      end
   endtask

   task automatic step(input bit v, input int a, input int b, input int d, input bit w,
                       input bit wv, input int wr, input bit r);
      bit rdy;
      @(negedge clk);
      rst = r; iss_valid = v; iss_we = w; wb_valid = wv;
      iss_rs1 = reg_addr_t'(a); iss_rs2 = reg_addr_t'(b);
      iss_rd = reg_addr_t'(d); wb_rd = reg_addr_t'(wr);
      #1;
      rdy = model_ready();
      chk("iss_ready", iss_ready, rdy);
      @(posedge clk);
      model_clock(rdy);
      #1;
      chk("busy", busy, model_busy());
      chk("out_cnt", out_cnt, cnt);
      chk("err_wb", err_wb, err);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      int q[$];
      int wr;
      rst = 1'b1; iss_valid = 0; iss_we = 0; wb_valid = 0;
      iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; wb_rd = '0;
      cnt = 0; err = 0;
      do_reset();
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_cnt", out_cnt, 0);
      chk("rst_err", err_wb, 0);

      // RAW on r5 released by write-back
      step(1, 0, 0, 5, 1, 0, 0, 0);
      chk("d_busy5", busy[5], 1);
      chk("d_cnt1", out_cnt, 1);
      step(1, 5, 0, 0, 0, 0, 0, 0);
      step(1, 5, 0, 0, 0, 1, 5, 0);
      step(1, 5, 0, 0, 0, 0, 0, 0);
      chk("d_clear5", busy[5], 0);

      // x0 never pending
      step(1, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("d_x0_busy", busy, 0);
      chk("d_x0_cnt", out_cnt, 0);

      // outstanding limit
      for (int i = 1; i <= 4; i++) step(1, 0, 0, i, 1, 0, 0, 0);
      chk("d_cnt4", out_cnt, 4);
      step(1, 0, 0, 6, 1, 0, 0, 0);
      chk("d_full_hold", busy[6], 0);
      step(1, 10, 11, 6, 0, 0, 0, 0);
      step(1, 0, 0, 6, 1, 1, 2, 0);
      step(1, 0, 0, 6, 1, 0, 0, 0);
      chk("d_busy6", busy[6], 1);

      // WAW on r7
      do_reset();
      step(1, 0, 0, 7, 1, 0, 0, 0);
      step(1, 0, 0, 7, 1, 0, 0, 0);
      step(1, 0, 0, 7, 1, 1, 7, 0);
      step(1, 0, 0, 7, 1, 0, 0, 0);

      // stray write-back, sticky error
      step(0, 0, 0, 0, 0, 1, 9, 0);
      chk("d_err", err_wb, 1);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 12, 1, 0, 0, 0);
      chk("d_err_sticky", err_wb, 1);

      // concurrent set and clear, then reset with count 3
      do_reset();
      step(1, 0, 0, 8, 1, 0, 0, 0);
      step(1, 0, 0, 1, 1, 0, 0, 0);
      step(1, 0, 0, 3, 1, 1, 8, 0);
      chk("d_set3", busy[3], 1);
      chk("d_clr8", busy[8], 0);
      step(1, 0, 0, 4, 1, 0, 0, 0);
      chk("d_cnt3", out_cnt, 3);
      step(1, 0, 0, 9, 1, 1, 4, 1);
      chk("d_rst_all", {busy, out_cnt, err_wb}, 0);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         q.delete();
         for (int i = 1; i < NREG; i++) if (pend[i]) q.push_back(i);
         if (q.size() > 0 && $urandom_range(0, 3) != 0) wr = q[$urandom_range(0, q.size() - 1)];
         else wr = int'($urandom_range(0, 15));
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0, wr, $urandom_range(0, 199) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
